// File: rtl/audioplay_pio_pkg.sv
// audioplay_pio_pkg: register offsets and CTRL/STATUS bit positions for the audioplay PIO bank
package audioplay_pio_pkg;
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_SET    = 2'd1;
    localparam logic [1:0] REG_CLR    = 2'd2;
    localparam logic [1:0] REG_BLINK  = 2'd3;
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam int CTRL_BLINK_EN  = 0;
    localparam int CTRL_COMMIT    = 1;
    localparam int STAT_PHASE     = 0;
    localparam int STAT_PENDING   = 1;
endpackage

// File: rtl/audioplay_blink_prescaler.sv
// audioplay_blink_prescaler: blink phase toggling every DIV clocks while en; ports clk, reset (async high), en, phase
module audioplay_blink_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic phase
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/audioplay_pio_bank.sv
// audioplay_pio_bank: Avalon-MM bank of NUM_CH x WIDTH output channels with SET/CLR/BLINK; optional AUDIOPLAY_PIO_SHADOW_EN
// ports: clk, reset (async high), address {grp,reg}, chipselect, write_n, writedata, readdata (comb), out_port (ch0 in LSBs)
module audioplay_pio_bank
    import audioplay_pio_pkg::*;
#(
    parameter int unsigned WIDTH     = 7,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned BLINK_DIV = 4,
    localparam int ADDR_W = $clog2(NUM_CH + 1) + 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        address,
    input  logic                     chipselect,
    input  logic                     write_n,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    output logic [NUM_CH*WIDTH-1:0]  out_port
);
    localparam int GRP_W = ADDR_W - 2;
    logic [WIDTH-1:0] data_q [NUM_CH];
    logic [WIDTH-1:0] mask_q [NUM_CH];
    logic [WIDTH-1:0] act    [NUM_CH];
    logic             blink_en_q, phase, pending;
    logic [GRP_W-1:0] grp;
    logic [1:0]       rsel;
    logic             wr, glob;
    logic [WIDTH-1:0] wd;
    logic             unused_wd;
    assign grp       = address[ADDR_W-1:2];
    assign rsel      = address[1:0];
    assign wr        = chipselect & ~write_n;
    assign glob      = grp == GRP_W'(NUM_CH);
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                data_q[i] <= '0;
                mask_q[i] <= '0;
            end
            blink_en_q <= 1'b0;
        end else if (wr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (grp == GRP_W'(i)) begin
                    if (rsel == REG_BLINK)
                        mask_q[i] <= wd;
                    else
                        data_q[i] <= rsel == REG_SET ? data_q[i] | wd :
                                     rsel == REG_CLR ? data_q[i] & ~wd : wd;
                end
            end
            if (glob && rsel == REG_CTRL)
                blink_en_q <= writedata[CTRL_BLINK_EN];
        end
    end
`ifdef AUDIOPLAY_PIO_SHADOW_EN
    // data_q is the shadow copy; channels only see it once COMMIT copies it across
    logic [WIDTH-1:0] act_q [NUM_CH];
    logic             data_wr, commit;
    assign data_wr = wr && grp < GRP_W'(NUM_CH) && rsel != REG_BLINK;
    assign commit  = wr && glob && rsel == REG_CTRL && writedata[CTRL_COMMIT];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++)
                act_q[i] <= '0;
            pending <= 1'b0;
        end else begin
            if (commit)
                for (int i = 0; i < NUM_CH; i++)
                    act_q[i] <= data_q[i];
            pending <= commit ? 1'b0 : data_wr ? 1'b1 : pending;
        end
    end
    assign act = act_q;
`else
    assign act     = data_q;
    assign pending = 1'b0;
`endif
    audioplay_blink_prescaler #(.DIV(BLINK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (blink_en_q),
        .phase (phase)
    );
    always_comb begin
        readdata = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (grp == GRP_W'(i))
                readdata = rsel == REG_DATA  ? 32'(data_q[i]) :
                           rsel == REG_BLINK ? 32'(mask_q[i]) : 32'd0;
        if (glob && rsel == REG_CTRL)
            readdata[CTRL_BLINK_EN] = blink_en_q;
        if (glob && rsel == REG_STATUS) begin
            readdata[STAT_PHASE]   = phase;
            readdata[STAT_PENDING] = pending;
        end
    end
    for (genvar c = 0; c < NUM_CH; c++) begin : g_out
        assign out_port[c*WIDTH +: WIDTH] = act[c] & ~(mask_q[c] & {WIDTH{phase}});
    end
endmodule
